hazard_forward_controller: RTL and testbench
============================================

Name: hazard_forward_controller

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It keeps a shadow pipeline of destination-register and control bits for the ID/EX, EX/MEM and MEM/WB stages. From that state it drives the forwarding selects Ctrl_FwdA and Ctrl_FwdB for the first and second ALU source muxes, detects load-use hazards and inserts stalls, and issues flushes on taken branches. It sits beside the ID stage and feeds the EX-stage muxes and the PC and IF/ID write enables.

Parameters:
REG_ADDR_W, 5, register-number width.
CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
clk  in  1  pipeline clock.
rst_n  in  1  asynchronous active-low reset.
id_valid  in  1  a real instruction is in ID this cycle.
id_rs  in  REG_ADDR_W  rs of the ID instruction.
id_rt  in  REG_ADDR_W  rt of the ID instruction.
id_dest  in  REG_ADDR_W  destination register of the ID instruction.
id_regwrite  in  1  ID instruction writes the register file.
id_memread  in  1  ID instruction is a load.
ex_branch_taken  in  1  branch resolved taken in EX this cycle.
Ctrl_FwdA  out  2  rs select for the EX instruction: 0 = RegRs, 1 = fwdEx (EX/MEM), 2 = fwdMem (MEM/WB). Value 3 is never driven.
Ctrl_FwdB  out  2  rt select, same encoding as Ctrl_FwdA.
pc_write  out  1  PC update enable.
ifid_write  out  1  IF/ID register write enable.
idex_bubble  out  1  load a NOP into ID/EX.
flush_ifid  out  1  squash the IF/ID contents.
stall_cnt  out  CNT_W  number of load-use stall cycles.
flush_cnt  out  CNT_W  number of branch flushes.

Behaviour:
- Shadow registers: ex_{dest,regwrite,memread}, mem_{dest,regwrite}. Reset clears all of them to 0.
- Every clock edge: mem_* <= ex_*. ex_* <= ID fields only if id_valid, no stall and no flush; otherwise ex_* is loaded with 0 (bubble).
- Load-use hazard (combinational): haz = ex_memread & ex_dest!=0 & id_valid & (ex_dest==id_rs | ex_dest==id_rt).
- With haz=1: pc_write=0, ifid_write=0, idex_bubble=1. The bubble clears ex_memread, so the stall lasts exactly 1 cycle per load.
- Flush: if ex_branch_taken=1, then flush_ifid=1 and idex_bubble=1 in the same cycle. Flush has priority over stall: pc_write=1 and ifid_write=1 so the target is fetched.
- FSM with states RUN, STALL, FLUSH. State is registered for the counters and debug; outputs come from the combinational terms above.
  - RUN -> STALL on haz.
  - RUN or STALL -> FLUSH on branch.
  - STALL or FLUSH -> RUN otherwise.
- Forwarding selects are computed in ID and registered on the edge that moves the instruction into EX, so they are valid for the whole EX cycle:
  - FwdA_next = 1 if ex_regwrite & ex_dest!=0 & ex_dest==id_rs.
  - Otherwise FwdA_next = 2 if mem_regwrite & mem_dest!=0 & mem_dest==id_rs.
  - Otherwise FwdA_next = 0.
  - FwdB_next is identical using id_rt.
  - EX/MEM wins when both stages match (most recent producer).
- A bubble or flush loads Ctrl_FwdA and Ctrl_FwdB with 0.
- Register $0 never forwards and never causes a stall.
- Reset values: Ctrl_FwdA=0, Ctrl_FwdB=0, state=RUN, counters=0. pc_write=1, ifid_write=1 and idex_bubble=0 while held in reset. flush_ifid follows ex_branch_taken.
- Reset asserted mid-stall: the shadow state clears immediately, the stall drops asynchronously, and pc_write returns to 1.

Optional Feature:
Macro HAZ_PERF_CNT_EN.
- Defined: stall_cnt increments each cycle with haz=1 and no flush. flush_cnt increments each cycle with ex_branch_taken=1. Both saturate at all-ones and clear on reset.
- Undefined: no counter flops are built and stall_cnt and flush_cnt are tied to 0.

Test Plan:
1. Load-use: lw $8 in EX, ID add $9,$8,$10 -> pc_write=0, ifid_write=0, idex_bubble=1 for 1 cycle. Next cycle no stall. When the add reaches EX, Ctrl_FwdA=2.
2. Back-to-back ALU: add $8 then sub $11,$12,$8 -> Ctrl_FwdB=1, Ctrl_FwdA=0 in the sub's EX cycle, no stall.
3. Double hit: $8 written in both EX/MEM and MEM/WB, ID uses $8 as rs and rt -> Ctrl_FwdA=1, Ctrl_FwdB=1.
4. $0: lw $0 then add $9,$0,$0 -> no stall, Ctrl_FwdA=0, Ctrl_FwdB=0.
5. Stall plus branch: haz=1 and ex_branch_taken=1 in the same cycle -> flush_ifid=1, idex_bubble=1, pc_write=1. Next EX has Ctrl_FwdA=0. With HAZ_PERF_CNT_EN: flush_cnt=1, stall_cnt=0.
6. Reset: rst_n dropped during a stall cycle -> pc_write=1 and Ctrl_FwdA=Ctrl_FwdB=0 immediately. After release, the first instruction runs with no stall.

Source files
------------

// File: rtl/hazard_forward_controller.sv
// Hazard controller for the 5-stage MIPS core: forwarding selects, load-use stalls, branch flushes.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_forward_controller #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_dest,
   input  logic                  id_regwrite,
   input  logic                  id_memread,
   input  logic                  ex_branch_taken,
   output logic [1:0]            Ctrl_FwdA,
   output logic [1:0]            Ctrl_FwdB,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  idex_bubble,
   output logic                  flush_ifid,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

   state_t                state_q, state_d;
   logic [REG_ADDR_W-1:0] ex_dest, mem_dest;
   logic                  ex_regwrite, ex_memread, mem_regwrite;
   logic                  haz, flush, stall, id_load;
   logic [1:0]            fwd_a_d, fwd_b_d;

   // EX/MEM is the most recent producer, so it wins over MEM/WB.
   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
      if (ex_regwrite && (ex_dest != '0) && (ex_dest == src))
         return 2'd1;
      else if (mem_regwrite && (mem_dest != '0) && (mem_dest == src))
         return 2'd2;
      else
         return 2'd0;
   endfunction

   always_comb begin
      haz     = ex_memread && (ex_dest != '0) && id_valid &&
                ((ex_dest == id_rs) || (ex_dest == id_rt));
      flush   = ex_branch_taken;
      stall   = haz && !flush;
      id_load = id_valid && !haz && !flush;
      fwd_a_d = fwd_sel(id_rs);
      fwd_b_d = fwd_sel(id_rt);
   end

   always_comb begin
      pc_write    = !stall;
      ifid_write  = !stall;
      idex_bubble = rst_n && (haz || flush);
      flush_ifid  = ex_branch_taken;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (flush) state_d = FLUSH;
                  else if (haz) state_d = STALL;
         STALL:   state_d = flush ? FLUSH : RUN;
         FLUSH:   state_d = flush ? FLUSH : RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         ex_dest      <= '0;
         ex_regwrite  <= 1'b0;
         ex_memread   <= 1'b0;
         mem_dest     <= '0;
         mem_regwrite <= 1'b0;
         Ctrl_FwdA    <= 2'd0;
         Ctrl_FwdB    <= 2'd0;
      end else begin
         state_q      <= state_d;
         mem_dest     <= ex_dest;
         mem_regwrite <= ex_regwrite;
         if (id_load) begin
            ex_dest     <= id_dest;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            Ctrl_FwdA   <= fwd_a_d;
            Ctrl_FwdB   <= fwd_b_d;
         end else begin
            ex_dest     <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            Ctrl_FwdA   <= 2'd0;
            Ctrl_FwdB   <= 2'd0;
         end
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
         if (flush && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_controller.sv
// Table-driven bench for hazard_forward_controller with an expected-result queue.
module tb_hazard_forward_controller;

   localparam int unsigned NV = 20;

   typedef struct {
      logic       rst_n, vld;
      logic [4:0] rs, rt, dst;
      logic       rw, mr, br;
      logic [1:0] fa, fb;
      logic       pcw, ifw, bub, fl;
   } vec_t;

   typedef struct {
      logic [1:0]  fa, fb;
      logic        pcw, ifw, bub, fl;
      logic [15:0] sc, fc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid = 1'b0;
   logic [4:0]  id_rs = '0, id_rt = '0, id_dest = '0;
   logic        id_regwrite = 1'b0, id_memread = 1'b0, ex_branch_taken = 1'b0;
   logic [1:0]  Ctrl_FwdA, Ctrl_FwdB;
   logic        pc_write, ifid_write, idex_bubble, flush_ifid;
   logic [15:0] stall_cnt, flush_cnt;

   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;
   logic [15:0] exp_sc = '0, exp_fc = '0;
   exp_t        sb[$];
   vec_t        tbl[NV];

   hazard_forward_controller #(.REG_ADDR_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .ex_branch_taken(ex_branch_taken), .Ctrl_FwdA(Ctrl_FwdA), .Ctrl_FwdB(Ctrl_FwdB),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
      .flush_ifid(flush_ifid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(logic r, logic v, int rs, int rt, int d, logic rw, logic mr,
                               logic br, int fa, int fb, logic pcw, logic ifw, logic bub,
                               logic fl);
      vec_t t;
      t.rst_n = r; t.vld = v; t.rs = 5'(rs); t.rt = 5'(rt); t.dst = 5'(d);
      t.rw = rw; t.mr = mr; t.br = br; t.fa = 2'(fa); t.fb = 2'(fb);
      t.pcw = pcw; t.ifw = ifw; t.bub = bub; t.fl = fl;
      return t;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      total_cnt++;
      if (act == req) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, req);
   endtask

   task automatic drive(input vec_t t);
      exp_t e;
      rst_n = t.rst_n; id_valid = t.vld; id_rs = t.rs; id_rt = t.rt; id_dest = t.dst;
      id_regwrite = t.rw; id_memread = t.mr; ex_branch_taken = t.br;
      e.fa = t.fa; e.fb = t.fb; e.pcw = t.pcw; e.ifw = t.ifw; e.bub = t.bub; e.fl = t.fl;
      e.sc = exp_sc; e.fc = exp_fc;
      sb.push_back(e);
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_fwdA"}, int'(Ctrl_FwdA), int'(e.fa));
      chk({tag, "_fwdB"}, int'(Ctrl_FwdB), int'(e.fb));
      chk({tag, "_pc_write"}, int'(pc_write), int'(e.pcw));
      chk({tag, "_ifid_write"}, int'(ifid_write), int'(e.ifw));
      chk({tag, "_bubble"}, int'(idex_bubble), int'(e.bub));
      chk({tag, "_flush"}, int'(flush_ifid), int'(e.fl));
      chk({tag, "_stall_cnt"}, int'(stall_cnt), int'(e.sc));
      chk({tag, "_flush_cnt"}, int'(flush_cnt), int'(e.fc));
   endtask

   task automatic count_update(input vec_t t);
`ifdef HAZ_PERF_CNT_EN
      if (!t.rst_n) begin
         exp_sc = '0;
         exp_fc = '0;
      end else begin
         if (!t.pcw && exp_sc != 16'hFFFF) exp_sc++;
         if (t.br && exp_fc != 16'hFFFF) exp_fc++;
      end
`else
      exp_sc = '0;
      exp_fc = '0;
`endif
   endtask

   initial begin
      //            rst v  rs rt  d rw mr br  fa fb pcw ifw bub fl
      tbl[0]  = mk(0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 1, 1, 0, 1); // reset, branch visible
      tbl[1]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 1, 0, 0);
      tbl[2]  = mk(1, 1, 9, 8,  8, 1, 1, 0,  0, 0, 1, 1, 0, 0); // lw $8
      tbl[3]  = mk(1, 1, 8, 10, 9, 1, 0, 0,  0, 0, 0, 0, 1, 0); // add $9,$8,$10 stalls
      tbl[4]  = mk(1, 1, 8, 10, 9, 1, 0, 0,  0, 0, 1, 1, 0, 0); // retried, no stall
      tbl[5]  = mk(1, 1, 1, 2,  8, 1, 0, 0,  2, 0, 1, 1, 0, 0); // add in EX: FwdA=2
      tbl[6]  = mk(1, 1, 12, 8, 11, 1, 0, 0, 0, 0, 1, 1, 0, 0); // sub $11,$12,$8
      tbl[7]  = mk(1, 1, 1, 2,  8, 1, 0, 0,  0, 1, 1, 1, 0, 0); // sub in EX: FwdB=1
      tbl[8]  = mk(1, 1, 3, 4,  8, 1, 0, 0,  0, 0, 1, 1, 0, 0);
      tbl[9]  = mk(1, 1, 8, 8, 12, 1, 0, 0,  0, 0, 1, 1, 0, 0); // $8 in EX/MEM and MEM/WB
      tbl[10] = mk(1, 0, 0, 0,  0, 0, 0, 0,  1, 1, 1, 1, 0, 0); // double hit: 1,1
      tbl[11] = mk(1, 1, 9, 0,  0, 1, 1, 0,  0, 0, 1, 1, 0, 0); // lw $0
      tbl[12] = mk(1, 1, 0, 0,  9, 1, 0, 0,  0, 0, 1, 1, 0, 0); // add $9,$0,$0 no stall
      tbl[13] = mk(1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 1, 0, 0); // no forward of $0
      tbl[14] = mk(1, 1, 9, 8,  8, 1, 1, 0,  0, 0, 1, 1, 0, 0); // lw $8, rs $9 from MEM/WB
      tbl[15] = mk(1, 1, 8, 10, 9, 1, 0, 1,  2, 0, 1, 1, 1, 1); // haz + branch: flush wins
      tbl[16] = mk(1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 1, 0, 0); // flushed EX: FwdA=0
      tbl[17] = mk(1, 1, 1, 2,  5, 1, 0, 0,  0, 0, 1, 1, 0, 0); // add $5
      tbl[18] = mk(1, 1, 5, 8,  8, 1, 1, 0,  0, 0, 1, 1, 0, 0); // lw $8,($5)
      tbl[19] = mk(1, 1, 8, 10, 9, 1, 0, 0,  1, 0, 0, 0, 1, 0); // stall with FwdA=1 held

      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         drive(tbl[i]);
         @(negedge clk);
         check_out($sformatf("row%0d", i));
         count_update(tbl[i]);
      end

      // Reset dropped in the middle of the stall cycle above.
      #2;
      rst_n = 1'b0;
      exp_sc = '0;
      exp_fc = '0;
      sb.push_back('{fa: 2'd0, fb: 2'd0, pcw: 1'b1, ifw: 1'b1, bub: 1'b0, fl: 1'b0,
                     sc: 16'd0, fc: 16'd0});
      #1;
      check_out("rst_mid_stall");

      @(posedge clk); #1;
      drive(mk(1, 1, 8, 10, 9, 1, 0, 0, 0, 0, 1, 1, 0, 0));
      @(negedge clk);
      check_out("post_rst_first");

      @(posedge clk); #1;
      drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      @(negedge clk);
      check_out("post_rst_ex");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
